ycbcr444_rgb888: RTL

Pipelined YCbCr 4:4:4 to RGB888 colour-space converter for the video processing chain, the inverse of the forward RGB888→YCbCr444 stage. It sits after any luma/chroma processing and before display or RGB-domain filters. Frame and line strobes pass through aligned with the pixels. The block also counts clipped pixels per frame as a gamut/quality diagnostic.

---
 rtl/ycbcr_pkg.sv | 24 ++
 rtl/sat_u8.sv | 23 ++
 rtl/ycbcr444_rgb888.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ycbcr_pkg.sv
// Shared constants and types for the YCbCr 4:4:4 to RGB888 converter.
// Coefficients are Q8 fixed point (value * 256).
package ycbcr_pkg;

    localparam int C_RCR = 359;
    localparam int C_GCB = 88;
    localparam int C_GCR = 183;
    localparam int C_BCB = 454;
    localparam int C_RND = 128;
    localparam int C_OFS = 128;
    localparam int LAT   = 4;

    localparam int SUM_W = 19;

    typedef logic signed [SUM_W-1:0] sum_t;
    typedef logic signed [8:0]       chroma_t;

    typedef struct packed {
        logic vsync;
        logic href;
        logic armed;
    } sync_t;

endpackage

// File: rtl/sat_u8.sv
// Clamps a signed Q8 channel sum to an unsigned 8-bit pixel value and
// reports whether saturation occurred.
module sat_u8
    import ycbcr_pkg::*;
(
    input  logic signed [SUM_W-1:0] value,
    output logic        [7:0]       result,
    output logic                    clip
);

    always_comb begin
        result = value[15:8];
        clip   = 1'b0;
        if (value[SUM_W-1]) begin
            result = 8'd0;
            clip   = 1'b1;
        end else if (|value[SUM_W-2:16]) begin
            result = 8'hFF;
            clip   = 1'b1;
        end
    end

endmodule

// File: rtl/ycbcr444_rgb888.sv
// Four-stage YCbCr 4:4:4 to RGB888 converter with aligned frame/line strobes
// and a per-frame count of pixels that saturated in any channel.
module ycbcr444_rgb888
    import ycbcr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic [7:0]  per_img_Y,
    input  logic [7:0]  per_img_Cb,
    input  logic [7:0]  per_img_Cr,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic [7:0]  post_img_red,
    output logic [7:0]  post_img_green,
    output logic [7:0]  post_img_blue,
    output logic [15:0] clip_cnt,
    output logic        clip_cnt_valid
);

    localparam sum_t    K_RCR = sum_t'(C_RCR);
    localparam sum_t    K_GCB = sum_t'(C_GCB);
    localparam sum_t    K_GCR = sum_t'(C_GCR);
    localparam sum_t    K_BCB = sum_t'(C_BCB);
    localparam sum_t    K_RND = sum_t'(C_RND);
    localparam chroma_t K_OFS = chroma_t'(C_OFS);

    chroma_t     cb_s1, cr_s1;
    logic [16:0] y_s1, y_s2;
    sum_t        p_rcr, p_gcb, p_gcr, p_bcb;
    sum_t        r_s3, g_s3, b_s3;
    sync_t       sync_pipe [LAT];
    logic        in_armed;

    logic [7:0]  r_sat, g_sat, b_sat;
    logic        r_clip, g_clip, b_clip;
    logic        clip_s4;

    logic        vs_hist;
    logic        frame_open;
    logic [15:0] clip_run;
    logic        vs_rise, vs_fall, pix_clip;

    sat_u8 u_sat_r (.value(r_s3), .result(r_sat), .clip(r_clip));
    sat_u8 u_sat_g (.value(g_s3), .result(g_sat), .clip(g_clip));
    sat_u8 u_sat_b (.value(b_s3), .result(b_sat), .clip(b_clip));

    // in_armed marks pixels that follow a vsync-low period since reset, so a
    // frame already in flight when reset releases is never reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            cb_s1          <= '0;
            cr_s1          <= '0;
            y_s1           <= '0;
            y_s2           <= '0;
            p_rcr          <= '0;
            p_gcb          <= '0;
            p_gcr          <= '0;
            p_bcb          <= '0;
            r_s3           <= '0;
            g_s3           <= '0;
            b_s3           <= '0;
            post_img_red   <= '0;
            post_img_green <= '0;
            post_img_blue  <= '0;
            clip_s4        <= 1'b0;
            in_armed       <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                sync_pipe[i] <= '0;
            end
        end else begin
            cb_s1 <= chroma_t'({1'b0, per_img_Cb}) - K_OFS;
            cr_s1 <= chroma_t'({1'b0, per_img_Cr}) - K_OFS;
            y_s1  <= {1'b0, per_img_Y, 8'd0};

            p_rcr <= sum_t'(cr_s1) * K_RCR;
            p_gcb <= sum_t'(cb_s1) * K_GCB;
            p_gcr <= sum_t'(cr_s1) * K_GCR;
            p_bcb <= sum_t'(cb_s1) * K_BCB;
            y_s2  <= y_s1;

            r_s3 <= sum_t'(y_s2) + p_rcr + K_RND;
            g_s3 <= sum_t'(y_s2) - p_gcb - p_gcr + K_RND;
            b_s3 <= sum_t'(y_s2) + p_bcb + K_RND;

            post_img_red   <= sync_pipe[LAT-2].href ? r_sat : 8'd0;
            post_img_green <= sync_pipe[LAT-2].href ? g_sat : 8'd0;
            post_img_blue  <= sync_pipe[LAT-2].href ? b_sat : 8'd0;
            clip_s4        <= r_clip | g_clip | b_clip;

            in_armed     <= in_armed | ~per_frame_vsync;
            sync_pipe[0] <= {per_frame_vsync, per_frame_href, in_armed};
            for (int i = 1; i < LAT; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign post_frame_vsync = sync_pipe[LAT-1].vsync;
    assign post_frame_href  = sync_pipe[LAT-1].href;

    assign vs_rise  = post_frame_vsync & ~vs_hist;
    assign vs_fall  = ~post_frame_vsync & vs_hist;
    assign pix_clip = post_frame_href & clip_s4;

    // A clear on the first pixel of a frame still counts that pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_hist        <= 1'b0;
            frame_open     <= 1'b0;
            clip_run       <= '0;
            clip_cnt       <= '0;
            clip_cnt_valid <= 1'b0;
        end else begin
            vs_hist        <= post_frame_vsync;
            clip_cnt_valid <= 1'b0;
            if (vs_rise) begin
                clip_run   <= pix_clip ? 16'd1 : 16'd0;
                frame_open <= sync_pipe[LAT-1].armed;
            end else if (pix_clip && clip_run != 16'hFFFF) begin
                clip_run <= clip_run + 16'd1;
            end
            if (vs_fall && frame_open) begin
                clip_cnt       <= clip_run;
                clip_cnt_valid <= 1'b1;
                frame_open     <= 1'b0;
            end
        end
    end

endmodule
